// File: rtl/seg7_scan_if.sv
// seg7_scan_if: scan-driver bus grouping tick/load/data inputs and display outputs
interface seg7_scan_if #(
  parameter int N_DIGITS = 4
);
  logic                    tick;
  logic [4*N_DIGITS-1:0]   data_in;
  logic [N_DIGITS-1:0]     dp_in;
  logic                    load;
  logic                    lz_blank;
  logic [N_DIGITS-1:0]     an;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_start;
  modport master (
    output tick, data_in, dp_in, load, lz_blank,
    input  an, seg, dp, frame_start
  );
  modport slave (
    input  tick, data_in, dp_in, load, lz_blank,
    output an, seg, dp, frame_start
  );
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed common-anode 7-segment scanner with frame-synchronous double buffer
module seg7_scan #(
  parameter int N_DIGITS    = 4,
  parameter int BLANK_TICKS = 1,
  parameter int ON_TICKS    = 3
) (
  input  logic            clk_in,
  input  logic            RST,
  seg7_scan_if.slave      bus
);
  localparam int MAXT = (BLANK_TICKS > ON_TICKS) ? BLANK_TICKS : ON_TICKS;
  localparam int TW   = $clog2(MAXT + 1);
  localparam int IW   = $clog2(N_DIGITS);
  localparam logic [TW-1:0] B_LAST = TW'(BLANK_TICKS - 1);
  localparam logic [TW-1:0] O_LAST = TW'(ON_TICKS - 1);
  localparam logic [IW-1:0] I_LAST = IW'(N_DIGITS - 1);
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  typedef enum logic {BLANK, ON} state_t;
  state_t                r_state, w_state_n;
  logic [TW-1:0]         r_tcnt, w_tcnt_n;
  logic [IW-1:0]         r_idx, w_idx_n;
  logic                  w_wrap;
  logic [4*N_DIGITS-1:0] r_sh_data, r_pd_data;
  logic [N_DIGITS-1:0]   r_sh_dp, r_pd_dp;
  logic                  r_pend_v;
  logic [N_DIGITS-1:0]   r_an, w_an_n;
  logic [6:0]            r_seg, w_seg_n;
  logic                  r_dp, w_dp_n;
  logic [N_DIGITS-1:0]   w_lz;
  logic                  w_run;
  logic [3:0]            w_nib;
  logic                  w_blank;
  // Slot sequencer: BLANK then ON per digit, advancing only on tick; flags the frame wrap
  always_comb begin
    w_state_n = r_state;
    w_tcnt_n  = r_tcnt;
    w_idx_n   = r_idx;
    w_wrap    = 1'b0;
    if (bus.tick) begin
      if (r_state == BLANK) begin
        w_state_n = (r_tcnt == B_LAST) ? ON : BLANK;
        w_tcnt_n  = (r_tcnt == B_LAST) ? '0 : r_tcnt + 1'b1;
      end else begin
        w_state_n = (r_tcnt == O_LAST) ? BLANK : ON;
        w_tcnt_n  = (r_tcnt == O_LAST) ? '0 : r_tcnt + 1'b1;
        w_idx_n   = (r_tcnt != O_LAST) ? r_idx : (r_idx == I_LAST) ? '0 : r_idx + 1'b1;
        w_wrap    = (r_tcnt == O_LAST) && (r_idx == I_LAST);
      end
    end
  end
  // Leading-zero mask: digit k is a candidate when it and every digit above it is 0 with dp off
  always_comb begin
    w_run = 1'b1;
    w_lz  = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      w_run = w_run & (r_sh_data[4*k +: 4] == 4'h0) & ~r_sh_dp[k];
      w_lz[k] = w_run && (k != 0);
    end
  end
  // Next display values; idx never changes when entering ON, so the current idx is the lit digit
  always_comb begin
    w_nib   = r_sh_data[4*r_idx +: 4];
    w_blank = bus.lz_blank & w_lz[r_idx];
    w_an_n  = (w_state_n == ON) ? ~(N_DIGITS'(1) << r_idx) : '1;
    w_seg_n = (w_state_n == ON && !w_blank) ? ~SEG_LUT[w_nib] : 7'h7F;
    w_dp_n  = (w_state_n == ON && !w_blank) ? ~r_sh_dp[r_idx] : 1'b1;
  end
  // Sequencer state register
  always_ff @(posedge clk_in) begin
    if (RST) begin
      r_state <= BLANK;
      r_tcnt  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_n;
      r_tcnt  <= w_tcnt_n;
      r_idx   <= w_idx_n;
    end
  end
  // Registered outputs, refreshed only on tick so they hold between ticks
  always_ff @(posedge clk_in) begin
    if (RST) begin
      r_an  <= '1;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else if (bus.tick) begin
      r_an  <= w_an_n;
      r_seg <= w_seg_n;
      r_dp  <= w_dp_n;
    end
  end
  // Double buffer: loads land in pending; shadow only changes at the frame wrap, a same-cycle load bypasses pending
  always_ff @(posedge clk_in) begin
    if (RST) begin
      r_sh_data <= '0;
      r_sh_dp   <= '0;
      r_pd_data <= '0;
      r_pd_dp   <= '0;
      r_pend_v  <= 1'b0;
    end else if (w_wrap) begin
      r_sh_data <= bus.load ? bus.data_in : r_pend_v ? r_pd_data : r_sh_data;
      r_sh_dp   <= bus.load ? bus.dp_in : r_pend_v ? r_pd_dp : r_sh_dp;
      r_pend_v  <= 1'b0;
    end else if (bus.load) begin
      r_pd_data <= bus.data_in;
      r_pd_dp   <= bus.dp_in;
      r_pend_v  <= 1'b1;
    end
  end
  assign bus.an          = r_an;
  assign bus.seg         = r_seg;
  assign bus.dp          = r_dp;
  assign bus.frame_start = w_wrap & ~RST;
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: randomized self-checking bench against a tick-count display model
module tb_seg7_scan;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  seg7_scan_if #(.N_DIGITS(4)) bus();
  seg7_scan #(.N_DIGITS(4), .BLANK_TICKS(1), .ON_TICKS(3)) dut (
    .clk_in (clk),
    .RST    (rst),
    .bus    (bus)
  );
  logic [6:0] lut [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  int n_chk = 0;
  int n_fail = 0;
  int cc = 0;
  int tmode = 0;
  int m_n;
  logic [15:0] m_sh, m_pd;
  logic [3:0]  m_shdp, m_pdp;
  logic        m_pv;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (tick#%0d cyc %0d)", tag, got, exp, m_n, cc);
    end
  endtask
  // One clock: display position is (ticks since reset) mod 16; each 4-tick slot is 1 blank + 3 lit
  task automatic cyc(input logic t);
    int pos, d;
    logic [3:0] nib;
    logic bl;
    bus.tick = t;
    #1;
    check("frame_start", 16'(bus.frame_start), 16'(!rst && t && ((m_n + 1) % 16 == 0)));
    if (rst) begin
      m_n = 0; m_sh = '0; m_shdp = '0; m_pd = '0; m_pdp = '0; m_pv = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      if (t) begin
        m_n++;
        pos = m_n % 16;
        d = pos / 4;
        if (pos % 4 == 0) begin
          e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
          nib = m_sh[4*d +: 4];
          bl = bus.lz_blank && d > 0 && (m_sh >> (4*d)) == 0 && (m_shdp >> d) == 0;
          e_an = ~(4'b0001 << d);
          e_seg = bl ? 7'h7F : ~lut[nib];
          e_dp = bl ? 1'b1 : ~m_shdp[d];
        end
      end
      if (t && m_n % 16 == 0) begin
        if (bus.load) begin
          m_sh = bus.data_in; m_shdp = bus.dp_in;
        end else if (m_pv) begin
          m_sh = m_pd; m_shdp = m_pdp;
        end
        m_pv = 1'b0;
      end else if (bus.load) begin
        m_pd = bus.data_in; m_pdp = bus.dp_in; m_pv = 1'b1;
      end
    end
    @(negedge clk);
    check("an", 16'(bus.an), 16'(e_an));
    check("seg", 16'(bus.seg), 16'(e_seg));
    check("dp", 16'(bus.dp), 16'(e_dp));
    check("one_anode", 16'($countones(~bus.an) <= 1), 16'd1);
  endtask
  task automatic tk();
    cc++;
    cyc(tmode == 2 || (tmode == 1 && cc % 4 == 0) || (tmode == 3 && $urandom_range(0, 2) == 0));
  endtask
  task automatic run(input int n);
    repeat (n) tk();
  endtask
  task automatic ld(input logic [15:0] d, input logic [3:0] p);
    bus.load = 1'b1; bus.data_in = d; bus.dp_in = p;
    tk();
    bus.load = 1'b0; bus.data_in = 16'($urandom); bus.dp_in = 4'($urandom);
  endtask
  task automatic wait_pos(input int p);
    int g = 0;
    while (m_n % 16 != p && g < 400) begin tk(); g++; end
    check("wait_pos", 16'(m_n % 16), 16'(p));
  endtask
  task automatic wait_bnd();
    int g = 0;
    while (!((cc + 1) % 4 == 0 && (m_n + 1) % 16 == 0) && g < 400) begin tk(); g++; end
    check("wait_bnd", 16'((m_n + 1) % 16), 16'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    bus.tick = 1'b0; bus.load = 1'b0; bus.data_in = '0; bus.dp_in = '0; bus.lz_blank = 1'b0;
    @(negedge clk);
    run(3);
    rst = 1'b0;
    run(8);
    tmode = 1;
    ld(16'h12AF, 4'b0100);
    run(140);
    bus.lz_blank = 1'b1;
    wait_pos(1);
    ld(16'h0000, 4'b0000);
    run(6);
    ld(16'h0042, 4'b0000);
    run(136);
    bus.lz_blank = 1'b0;
    wait_pos(2);
    ld(16'h1234, 4'b1000);
    wait_bnd();
    ld(16'hBEEF, 4'b0001);
    run(140);
    ld(16'h5678, 4'b0010);
    wait_pos(9);
    rst = 1'b1;
    tk();
    rst = 1'b0;
    run(140);
    tmode = 2;
    ld(16'hC0DE, 4'b0110);
    run(40);
    tmode = 3;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) bus.lz_blank = ~bus.lz_blank;
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1; tk(); rst = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        ld($urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 255)) : 16'($urandom), 4'($urandom_range(0, 15) & $urandom_range(0, 15)));
      end else begin
        tk();
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
